dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single Data_Memory port of the beta core between two requesters: the CPU load/store path (port C) and the fingerprint-image DMA loader (port D). It sits between the core's ALU-address/RD2 path and the memory. It uses a registered ownership FSM with a bounded-burst fairness rule. The CPU stalls whenever it has a request in flight that is not acknowledged.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width.
- `MAX_BURST`, 8, maximum consecutive acked beats per tenure while the other port is requesting. Must be ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `RESET`  in  1  reset, asynchronous, active-low.
- `cpu_req`  in  1  CPU access request; held until acked.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_adr`  in  AW  word address.
- `cpu_wd`  in  DW  write data.
- `cpu_rd`  out  DW  read data; valid when `cpu_ack`=1, otherwise 0.
- `cpu_ack`  out  1  beat accepted this cycle. The core stalls on `cpu_req & ~cpu_ack`.
- `dma_req`, `dma_we`, `dma_adr`, `dma_wd`, `dma_rd`, `dma_ack`: identical to the CPU port, for the DMA loader.
- `mem_adr`  out  AW  to Data_Memory `Adr`.
- `mem_wd`  out  DW  to `MWD`.
- `mem_wr`  out  1  to `MWR`.
- `mem_oe`  out  1  to `MOE`.
- `mem_rd`  in  DW  from `MRD`; combinational read.

## Operation
- State: `owner` ∈ {NONE, CPU, DMA}, plus `beat_cnt` of width $clog2(MAX_BURST)+1.
- Memory mux: `mem_*` is driven from the owner port.
  - When owner=NONE: `mem_adr`=0, `mem_wd`=0, `mem_wr`=0, `mem_oe`=0.
- Acknowledge: `x_ack = (owner==x) & x_req`.
  - `mem_wr = ack & we`.
  - `mem_oe = ack & ~we`.
  - `x_rd = x_ack ? mem_rd : 0`.
- Transitions, evaluated every cycle:
  - NONE: if `cpu_req` → CPU. Else if `dma_req` → DMA. Else stay. CPU wins a simultaneous request.
  - CPU, `cpu_req` low: → DMA if `dma_req`, else → NONE.
  - CPU, ack and `beat_cnt==MAX_BURST-1` and `dma_req`: → DMA (forced hand-over).
  - CPU, otherwise: stay.
  - DMA: symmetric to CPU, with the roles swapped. On release, go → CPU if `cpu_req`, else → NONE.
- `beat_cnt`:
  - Clears to 0 on every owner change.
  - Increments on each acked beat.
  - Saturates at MAX_BURST.
  - Counts only while the other port is requesting. Otherwise it holds at 0, so an uncontended owner keeps the port indefinitely.
- Requester inputs (adr/wd/we) may change only after ack. Behaviour on mid-request changes is undefined.

## Timing
- Reset (RESET=0) forces the following immediately, asynchronously:
  - `owner`=NONE, `beat_cnt`=0.
  - All `*_ack`=0, `mem_wr`=`mem_oe`=0, all `*_rd`=0, `mem_adr`=`mem_wd`=0.
- Reset mid-burst aborts the tenure. No partial write is issued after reset asserts.
- Grant latency from NONE: request in cycle N, ack in cycle N+1.
- A continuous owner gets one beat per cycle, zero added latency.
- Hand-over: the last beat of the old owner is in cycle N, and the new owner's first ack is in cycle N+1. There is no bubble on forced hand-over.
- Release on request drop costs one idle cycle, because the drop is seen in the same cycle with no ack.
- MAX_BURST=1 with both ports requesting gives strict C/D alternation, one beat each.
- `mem_rd` is sampled combinationally in the ack cycle. No read-data register.

## Structure
- Package `dmem_arb_pkg` contains:
  - `owner_e` typedef: NONE=2'b00, CPU=2'b01, DMA=2'b10.
  - Default `MAX_BURST` localparam.
- One sub-module, `burst_counter`: clear/increment/saturate counter that outputs `limit_hit` for the FSM.
- All FSM and mux logic lives in `dmem_arbiter`.

## Test plan
- Reset: assert RESET=0 while DMA owns mid-burst with `dma_we`=1 → `owner`=NONE and `mem_wr`=0 in the same cycle. After release, the first ack comes 1 cycle after a request.
- Single CPU: `cpu_req`=1, we=1, adr=0x10, wd=0xDEADBEEF, then a read of 0x10 → ack at N+1 and N+2, read returns 0xDEADBEEF. `dma_ack` stays 0.
- Simultaneous request from NONE: both rise in cycle 0 → `cpu_ack` in cycle 1, `dma_ack`=0.
- Fairness, MAX_BURST=8, both held high: exactly 8 consecutive CPU acks, then 8 DMA acks, repeating. No gap cycles.
- Uncontended DMA: 100-beat burst with `cpu_req`=0 → 100 consecutive acks, `beat_cnt` stays 0. `cpu_req` rising at beat 40 → hand-over after DMA beat 47.
- Release: CPU drops req in cycle K with `dma_req`=1 → no ack in K, `dma_ack` in K+1. With `dma_req`=0, owner goes to NONE and all strobes are 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - ownership encoding and defaults for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    CPU  = 2'b01,
    DMA  = 2'b10
  } owner_e;

  localparam int MAX_BURST_DEFAULT = 8;

endpackage

// File: rtl/burst_counter.sv
// rtl/burst_counter.sv - per-tenure contended beat counter with saturation and limit flag
module burst_counter #(
  parameter int MAX_BURST = 8,
  parameter int CW        = $clog2(MAX_BURST) + 1
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          limit_hit
);

  localparam logic [CW-1:0] LIMIT = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] SAT   = CW'(MAX_BURST);

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != SAT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Flags the beat that completes the tenure's allowance.
  assign limit_hit = (cnt == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the Data_Memory port between CPU and DMA with bounded bursts
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_adr,
  input  logic [DW-1:0] dma_wd,
  output logic [DW-1:0] dma_rd,
  output logic          dma_ack,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_wr,
  output logic          mem_oe,
  input  logic [DW-1:0] mem_rd
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  owner_e        owner;
  owner_e        owner_nxt;
  logic [CW-1:0] beat_cnt;
  logic          limit_hit;
  logic          oth_req;
  logic          any_ack;
  logic          burst_clr;

  assign cpu_ack = (owner == CPU) & cpu_req;
  assign dma_ack = (owner == DMA) & dma_req;
  assign any_ack = cpu_ack | dma_ack;

  always_comb begin
    oth_req = 1'b0;
    case (owner)
      CPU:     oth_req = dma_req;
      DMA:     oth_req = cpu_req;
      default: oth_req = 1'b0;
    endcase
  end

  always_comb begin
    owner_nxt = owner;
    case (owner)
      NONE: begin
        if (cpu_req)      owner_nxt = CPU;
        else if (dma_req) owner_nxt = DMA;
      end
      CPU: begin
        if (!cpu_req)                 owner_nxt = dma_req ? DMA : NONE;
        else if (limit_hit & dma_req) owner_nxt = DMA;
      end
      DMA: begin
        if (!dma_req)                 owner_nxt = cpu_req ? CPU : NONE;
        else if (limit_hit & cpu_req) owner_nxt = CPU;
      end
      default: owner_nxt = NONE;
    endcase
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      owner <= NONE;
    end else begin
      owner <= owner_nxt;
    end
  end

  // An uncontended owner never accumulates beats, so it keeps the port indefinitely.
  assign burst_clr = (owner_nxt != owner) | ~oth_req;

  burst_counter #(
    .MAX_BURST(MAX_BURST),
    .CW       (CW)
  ) u_burst (
    .clk      (clk),
    .RESET    (RESET),
    .clr      (burst_clr),
    .inc      (any_ack),
    .cnt      (beat_cnt),
    .limit_hit(limit_hit)
  );

  always_comb begin
    mem_adr = '0;
    mem_wd  = '0;
    mem_wr  = 1'b0;
    mem_oe  = 1'b0;
    case (owner)
      CPU: begin
        mem_adr = cpu_adr;
        mem_wd  = cpu_wd;
        mem_wr  = cpu_ack & cpu_we;
        mem_oe  = cpu_ack & ~cpu_we;
      end
      DMA: begin
        mem_adr = dma_adr;
        mem_wd  = dma_wd;
        mem_wr  = dma_ack & dma_we;
        mem_oe  = dma_ack & ~dma_we;
      end
      default: ;
    endcase
  end

  assign cpu_rd = cpu_ack ? mem_rd : '0;
  assign dma_rd = dma_ack ? mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        RESET;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_adr, cpu_wd, dma_adr, dma_wd;
  logic [31:0] cpu_rd, dma_rd, mem_adr, mem_wd, mem_rd;
  logic        cpu_ack, dma_ack, mem_wr, mem_oe;

  logic [31:0] cpu_rd1, dma_rd1, mem_adr1, mem_wd1;
  logic        cpu_ack1, dma_ack1, mem_wr1, mem_oe1;

  int checks = 0;
  int errors = 0;

  int m_own;
  int m_streak;

  logic [31:0] mem [0:255];
  logic [31:0] shadow [0:255];
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wd(dma_wd),
    .dma_rd(dma_rd), .dma_ack(dma_ack),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_wr(mem_wr), .mem_oe(mem_oe),
    .mem_rd(mem_rd)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(1)) dut1 (
    .clk(clk), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd1), .cpu_ack(cpu_ack1),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wd(dma_wd),
    .dma_rd(dma_rd1), .dma_ack(dma_ack1),
    .mem_adr(mem_adr1), .mem_wd(mem_wd1), .mem_wr(mem_wr1), .mem_oe(mem_oe1),
    .mem_rd(32'h0)
  );

  // Data_Memory stand-in: combinational read, write on the rising edge.
  assign mem_rd = mem[mem_adr[7:0]];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
      mem_ready <= 1'b1;
    end else if (mem_wr) begin
      mem[mem_adr[7:0]] <= mem_wd;
    end
  end

  // Reference arbitration: a port keeps the memory while it requests, unless it has
  // already taken MAXB beats in a row with the other port waiting.
  function automatic void model_advance(input logic creq, input logic dreq);
    logic mine, other;
    if (m_own == 0) begin
      m_own    = creq ? 1 : (dreq ? 2 : 0);
      m_streak = 0;
    end else begin
      mine  = (m_own == 1) ? creq : dreq;
      other = (m_own == 1) ? dreq : creq;
      if (!mine) begin
        m_own    = other ? 3 - m_own : 0;
        m_streak = 0;
      end else if (other) begin
        m_streak = m_streak + 1;
        if (m_streak >= MAXB) begin
          m_own    = 3 - m_own;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
    end
  endfunction

  task automatic go_idle();
    @(posedge clk); #1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b1; dma_we = 1'b1;
    cpu_adr = 32'h5; dma_adr = 32'h6; cpu_wd = 32'h11; dma_wd = 32'h22;
    #2;
    checks++;
    if ({cpu_ack, dma_ack, mem_wr, mem_oe} !== 4'b0000) begin
      errors++; $display("FAIL reset_strobes got=%b exp=0000", {cpu_ack, dma_ack, mem_wr, mem_oe});
    end
    checks++;
    if ((mem_adr | mem_wd | cpu_rd | dma_rd) !== 32'h0) begin
      errors++; $display("FAIL reset_buses got adr=%h wd=%h crd=%h drd=%h exp=0", mem_adr, mem_wd, cpu_rd, dma_rd);
    end
    checks++;
    if (dut.owner !== 2'b00) begin
      errors++; $display("FAIL reset_owner got=%b exp=00", dut.owner);
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk); @(negedge clk); RESET = 1'b1;

    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = 1'b1; dma_adr = 32'h20; dma_wd = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({dma_ack, mem_wr} !== 2'b11) begin
      errors++; $display("FAIL reset_midburst_beat got=%b exp=11", {dma_ack, mem_wr});
    end
    @(posedge clk); #1;
    dma_wd = 32'h8765_4321;
    #2; RESET = 1'b0; #1;
    checks++;
    if (dut.owner !== 2'b00) begin
      errors++; $display("FAIL reset_async_owner got=%b exp=00", dut.owner);
    end
    checks++;
    if ({dma_ack, mem_wr, mem_oe} !== 3'b000 || mem_adr !== 32'h0) begin
      errors++; $display("FAIL reset_async_strobes got=%b adr=%h exp=000 adr=0", {dma_ack, mem_wr, mem_oe}, mem_adr);
    end
    @(negedge clk); dma_req = 1'b0;
    @(negedge clk); RESET = 1'b1;
    checks++;
    if (mem[8'h20] !== 32'h1234_5678) begin
      errors++; $display("FAIL reset_no_partial_write got=%h exp=12345678", mem[8'h20]);
    end

    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++; $display("FAIL reset_grant_n got=%b exp=0", cpu_ack);
    end
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b1) begin
      errors++; $display("FAIL reset_grant_n1 got=%b exp=1", cpu_ack);
    end
    go_idle();
  endtask

  task automatic test_single_cpu();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 32'h10; cpu_wd = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++; $display("FAIL single_cycle_n got=%b exp=0", cpu_ack);
    end
    @(negedge clk);
    checks++;
    if ({cpu_ack, dma_ack, mem_wr, mem_oe} !== 4'b1010 || mem_adr !== 32'h10 || mem_wd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_write got=%b adr=%h wd=%h exp=1010 adr=10 wd=deadbeef",
                         {cpu_ack, dma_ack, mem_wr, mem_oe}, mem_adr, mem_wd);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_ack, dma_ack, mem_wr, mem_oe} !== 4'b1001 || cpu_rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_read got=%b rd=%h exp=1001 rd=deadbeef", {cpu_ack, dma_ack, mem_wr, mem_oe}, cpu_rd);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0 || cpu_rd !== 32'h0) begin
      errors++; $display("FAIL single_drop got ack=%b rd=%h exp ack=0 rd=0", cpu_ack, cpu_rd);
    end
    go_idle();
  endtask

  task automatic test_simultaneous();
    @(posedge clk); #1;
    cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_ack, dma_ack} !== 2'b00) begin
      errors++; $display("FAIL simul_cycle0 got=%b exp=00", {cpu_ack, dma_ack});
    end
    @(negedge clk);
    checks++;
    if ({cpu_ack, dma_ack} !== 2'b10) begin
      errors++; $display("FAIL simul_cycle1 got=%b exp=10", {cpu_ack, dma_ack});
    end
    go_idle();
  endtask

  task automatic test_fairness();
    logic ec, e1c;
    @(posedge clk); #1;
    cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0;
    cpu_adr = 32'h1; dma_adr = 32'h2;
    for (int k = 0; k <= 48; k++) begin
      @(negedge clk);
      ec  = (((k - 1) / MAXB) % 2) == 0;
      e1c = ((k - 1) % 2) == 0;
      checks++;
      if (k == 0 ? ({cpu_ack, dma_ack} !== 2'b00) : ({cpu_ack, dma_ack} !== {ec, !ec})) begin
        errors++; $display("FAIL fair_burst8 cyc=%0d got=%b exp=%b", k, {cpu_ack, dma_ack}, (k == 0) ? 2'b00 : {ec, !ec});
      end
      checks++;
      if (k == 0 ? ({cpu_ack1, dma_ack1} !== 2'b00) : ({cpu_ack1, dma_ack1} !== {e1c, !e1c})) begin
        errors++; $display("FAIL fair_burst1 cyc=%0d got=%b exp=%b", k, {cpu_ack1, dma_ack1}, (k == 0) ? 2'b00 : {e1c, !e1c});
      end
    end
    go_idle();
  endtask

  task automatic test_uncontended_dma();
    int acks, nz, cacks;
    logic ec, ed;
    acks = 0; nz = 0; cacks = 0;
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = 1'b1; dma_adr = 32'h40; dma_wd = $urandom;
    @(negedge clk);
    for (int b = 1; b <= 100; b++) begin
      @(negedge clk);
      if (dma_ack) acks++;
      if (cpu_ack) cacks++;
      if (dut.beat_cnt != 0) nz++;
      @(posedge clk); #1;
      dma_adr = 32'h40 + 32'(b % 64);
      dma_wd  = $urandom;
    end
    dma_req = 1'b0;
    checks++;
    if (acks != 100 || cacks != 0) begin
      errors++; $display("FAIL uncont_acks got dma=%0d cpu=%0d exp dma=100 cpu=0", acks, cacks);
    end
    checks++;
    if (nz != 0) begin
      errors++; $display("FAIL uncont_beat_cnt got nonzero_cycles=%0d exp=0", nz);
    end
    go_idle();

    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = 1'b0; dma_adr = 32'h41;
    @(negedge clk);
    for (int b = 1; b <= 48; b++) begin
      @(posedge clk); #1;
      if (b == 40) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h42;
      end
      @(negedge clk);
      ed = (b <= 47);
      ec = (b == 48);
      checks++;
      if ({cpu_ack, dma_ack} !== {ec, ed}) begin
        errors++; $display("FAIL handover_beat b=%0d got=%b exp=%b", b, {cpu_ack, dma_ack}, {ec, ed});
      end
    end
    go_idle();
  endtask

  task automatic test_release();
    @(posedge clk); #1;
    cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b1;
    cpu_adr = 32'h3; dma_adr = 32'h30; dma_wd = 32'hCAFE_0001;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({cpu_ack, dma_ack} !== 2'b10) begin
      errors++; $display("FAIL release_pre got=%b exp=10", {cpu_ack, dma_ack});
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_ack, dma_ack} !== 2'b00) begin
      errors++; $display("FAIL release_k got=%b exp=00", {cpu_ack, dma_ack});
    end
    @(negedge clk);
    checks++;
    if ({cpu_ack, dma_ack, mem_wr} !== 3'b011) begin
      errors++; $display("FAIL release_k1 got=%b exp=011", {cpu_ack, dma_ack, mem_wr});
    end
    @(posedge clk); #1;
    dma_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_ack, dma_ack, mem_wr, mem_oe} !== 4'b0000) begin
      errors++; $display("FAIL release_none_k got=%b exp=0000", {cpu_ack, dma_ack, mem_wr, mem_oe});
    end
    @(negedge clk);
    checks++;
    if (dut.owner !== 2'b00 || {mem_wr, mem_oe} !== 2'b00 || mem_adr !== 32'h0 || mem_wd !== 32'h0) begin
      errors++; $display("FAIL release_none_idle got owner=%b wr/oe=%b adr=%h wd=%h exp owner=00 all 0",
                         dut.owner, {mem_wr, mem_oe}, mem_adr, mem_wd);
    end
    go_idle();
  endtask

  task automatic test_random();
    logic c_pend, d_pend, ec, ed, ewr, eoe;
    c_pend = 1'b0; d_pend = 1'b0;
    m_own = 0; m_streak = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (!c_pend && $urandom_range(0, 3) != 0) begin
        c_pend = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_adr = 32'($urandom_range(0, 15)); cpu_wd = $urandom;
      end
      if (!d_pend && $urandom_range(0, 1) != 0) begin
        d_pend = 1'b1; dma_we = 1'($urandom_range(0, 1));
        dma_adr = 32'($urandom_range(0, 15)); dma_wd = $urandom;
      end
      cpu_req = c_pend;
      dma_req = d_pend;
      @(negedge clk);
      ec  = (m_own == 1) && cpu_req;
      ed  = (m_own == 2) && dma_req;
      ewr = (ec && cpu_we) || (ed && dma_we);
      eoe = (ec && !cpu_we) || (ed && !dma_we);
      checks++;
      if ({cpu_ack, dma_ack} !== {ec, ed}) begin
        errors++; $display("FAIL rand_ack cyc=%0d got=%b exp=%b", cyc, {cpu_ack, dma_ack}, {ec, ed});
      end
      checks++;
      if ({mem_wr, mem_oe} !== {ewr, eoe}) begin
        errors++; $display("FAIL rand_strobe cyc=%0d got=%b exp=%b", cyc, {mem_wr, mem_oe}, {ewr, eoe});
      end
      checks++;
      if (cpu_rd !== (ec ? shadow[cpu_adr[7:0]] : 32'h0)) begin
        errors++; $display("FAIL rand_cpu_rd cyc=%0d got=%h exp=%h", cyc, cpu_rd, ec ? shadow[cpu_adr[7:0]] : 32'h0);
      end
      checks++;
      if (dma_rd !== (ed ? shadow[dma_adr[7:0]] : 32'h0)) begin
        errors++; $display("FAIL rand_dma_rd cyc=%0d got=%h exp=%h", cyc, dma_rd, ed ? shadow[dma_adr[7:0]] : 32'h0);
      end
      if (ec || ed) begin
        checks++;
        if (mem_adr !== (ec ? cpu_adr : dma_adr) || mem_wd !== (ec ? cpu_wd : dma_wd)) begin
          errors++; $display("FAIL rand_mux cyc=%0d got adr=%h wd=%h exp adr=%h wd=%h", cyc, mem_adr, mem_wd,
                             ec ? cpu_adr : dma_adr, ec ? cpu_wd : dma_wd);
        end
      end
      if (ec) begin
        if (cpu_we) shadow[cpu_adr[7:0]] = cpu_wd;
        c_pend = 1'b0;
      end
      if (ed) begin
        if (dma_we) shadow[dma_adr[7:0]] = dma_wd;
        d_pend = 1'b0;
      end
      model_advance(cpu_req, dma_req);
    end
    go_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 32'hA500_0000 | i;
    RESET = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wd = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_adr = '0; dma_wd = '0;
    test_reset();
    test_single_cpu();
    test_simultaneous();
    test_fairness();
    test_uncontended_dma();
    test_release();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
